seg7_scan: RTL and testbench
============================

// Module: seg7_scan
// PURPOSE
//  Display back-end for the event-counter top. Consumes its 32-bit data_o and 4-bit layout_o.
//  Converts the value to 8 hex or decimal digits; decimal uses a sequential double-dabble sub-block.
//  Time-multiplexes the digits onto an 8-digit common-anode 7-segment display.
// PARAMETERS
//  NDIGITS     8       digits driven; fixed at 8 for this design
//  REFRESH_DIV 100000  clk cycles each digit stays lit; must be >= 2
// PORTS
//  clk_i     in   1   single clock, rising edge
//  rst_i     in   1   reset, synchronous, active-low (0 = reset)
//  data_i    in   32  value to display (unsigned)
//  layout_i  in   4   [1:0] mode: 00 hex, 01 decimal, 10 blank, 11 = hex; [2] leading-zero blank; [3] dp on digit 0
//  an_o      out  8   digit enables, active-low, one-hot-low when lit
//  seg_o     out  7   {g,f,e,d,c,b,a}, active-low
//  dp_o      out  1   decimal point, active-low
//  busy_o    out  1   1 while a conversion is in flight
// BEHAVIOUR
//  Reset (rst_i=0 at a clk edge):
//   - an_o=8'hFF, seg_o=7'h7F, dp_o=1, busy_o=0.
//   - FSM=IDLE, digit index=0, prescaler=0, display buffer=all-blank.
//   - Snapshot regs are cleared so the first post-reset cycle starts a conversion.
//   - Reset mid-conversion aborts it; the partial result is discarded.
//  Conversion FSM: IDLE -> SHIFT -> LOAD -> IDLE
//   - IDLE: if {data_i,layout_i} != snapshot, capture both into the snapshot, set busy_o=1.
//     Mode 01 -> SHIFT; any other mode -> LOAD.
//   - SHIFT: double dabble, 1 input bit per cycle, MSB first, into a 40-bit BCD reg.
//     Before each shift, add 3 to every nibble >= 5. Exactly 32 SHIFT cycles.
//   - LOAD: write all 8 digit codes to the display buffer in one cycle; busy_o=0 next cycle; -> IDLE.
//   - Latency capture -> buffer update: 34 cycles decimal, 2 cycles hex/blank.
//   - Inputs changing during SHIFT are ignored. The next IDLE cycle recompares and reconverts;
//     only the final settled value matters.
//  Digit mapping (digit 0 = rightmost):
//   - Hex: digit k = data[4k+3:4k].
//   - Decimal: digit k = BCD nibble k. If value > 99_999_999, show the low 8 BCD digits
//     and light all 8 dp (overflow flag).
//   - Blank mode: all digits blank; dp off, including layout_i[3].
//   - Leading-zero blank: zero digits above the highest nonzero digit are blank.
//     Digit 0 is never blanked, so value 0 shows "0".
//   - layout_i[3]=1: dp lit on digit 0 (OR with the overflow flag).
//  Glyphs: 0=7'h40 1=7'h79 2=7'h24 3=7'h30 4=7'h19 5=7'h12 6=7'h02 7=7'h78 8=7'h00 9=7'h10
//   A=7'h08 b=7'h03 C=7'h46 d=7'h21 E=7'h06 F=7'h0E blank=7'h7F.
//  Scan:
//   - Prescaler counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and the digit index
//     advances mod 8 (7 -> 0).
//   - an_o, seg_o, dp_o are registered from index and buffer: 1 cycle after an index change.
//   - Buffer update and index advance in the same cycle: the new digit shows new buffer content.
//   - No tearing: the buffer changes only in LOAD.
// STRUCTURE
//  Shared package seg7_pkg:
//   - mode encodings MODE_HEX/MODE_DEC/MODE_BLANK, glyph table function, GLYPH_BLANK,
//     DEC_MAX = 32'd99_999_999.
//  Sub-module bin2bcd (32-bit in, 40-bit BCD out):
//   - start/done handshake: start is a 1-cycle pulse, done is a 1-cycle pulse after the 32nd shift.
//   - Same clk_i/rst_i.
//  Top: FSM, snapshot regs, display buffer, prescaler/scan mux.
// TESTING (use REFRESH_DIV=4)
//  1. Reset for 3 cycles, release with data_i=0, layout=4'b0000:
//     -> outputs FF/7F/1 during reset; after 2 cycles all 8 digits scan as glyph 0 (7'h40).
//  2. data_i=32'h12AB_CDEF, hex:
//     -> busy_o high for 2 cycles; digit0..7 = F,E,d,C,b,A,2,1; an_o walks FE,FD,...,7F, 4 cycles each.
//  3. data_i=32'd1234, layout=4'b0101:
//     -> busy_o high for exactly 34 cycles; digits 4,3,2,1 then blank x4.
//  4. data_i=32'd4294967295, decimal:
//     -> digits 7..0 = 9,4,9,6,7,2,9,5; dp_o=0 on every digit.
//  5. Change data_i 10 cycles into SHIFT, then hold at 32'd7:
//     -> buffer never shows the first value; final display 00000007.
//  6. rst_i=0 mid-SHIFT, layout=4'b1010:
//     -> immediate reset outputs; afterwards all digits blank, dp_o=1.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7_scan display back-end.
//   - conversion FSM state encoding
//   - layout mode encodings, blank glyph, decimal display limit
//   - glyph table (active-low {g,f,e,d,c,b,a}) and the double-dabble nibble adjust
package seg7_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_LOAD  = 2'd2
   } state_e;

   localparam int          NDIGITS     = 8;
   localparam logic [1:0]  MODE_HEX    = 2'b00;
   localparam logic [1:0]  MODE_DEC    = 2'b01;
   localparam logic [1:0]  MODE_BLANK  = 2'b10;
   localparam logic [6:0]  GLYPH_BLANK = 7'h7F;
   localparam logic [31:0] DEC_MAX     = 32'd99_999_999;

   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'h40;
         4'h1:    g = 7'h79;
         4'h2:    g = 7'h24;
         4'h3:    g = 7'h30;
         4'h4:    g = 7'h19;
         4'h5:    g = 7'h12;
         4'h6:    g = 7'h02;
         4'h7:    g = 7'h78;
         4'h8:    g = 7'h00;
         4'h9:    g = 7'h10;
         4'hA:    g = 7'h08;
         4'hB:    g = 7'h03;
         4'hC:    g = 7'h46;
         4'hD:    g = 7'h21;
         4'hE:    g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   // Add 3 to every BCD nibble that is 5 or more, ahead of a left shift.
   function automatic logic [39:0] bcd_adjust(input logic [39:0] bcd);
      logic [39:0] r;
      r = bcd;
      for (int k = 0; k < 10; k++) begin
         if (bcd[4*k +: 4] >= 4'd5) begin
            r[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_scan_bin2bcd.sv
// Sequential 32-bit binary to 10-digit BCD converter (double dabble).
// One input bit per cycle, MSB first, 32 shifts in total. The first shift
// happens on the start edge itself, so done_o pulses in the cycle right
// after the 32nd shift, 32 cycles after start_i.
//   clk_i    clock, rising edge
//   rst_i    synchronous reset, active-low; aborts a conversion in flight
//   start_i  1-cycle pulse, samples bin_i
//   bin_i    unsigned binary value
//   bcd_o    40-bit BCD result, valid when done_o pulses
//   done_o   1-cycle pulse after the final shift
module seg7_scan_bin2bcd
   import seg7_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] bin_i,
   output logic [39:0] bcd_o,
   output logic        done_o
);

   logic [31:0] sh_q, sh_d;
   logic [39:0] bcd_q, bcd_d;
   logic [39:0] adj;
   logic [4:0]  cnt_q, cnt_d;
   logic        active_q, active_d;
   logic        done_q, done_d;

   always_comb begin
      sh_d     = sh_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      done_d   = 1'b0;
      adj      = bcd_adjust(bcd_q);
      if (start_i) begin
         // an all-zero BCD register needs no adjust before the first shift
         bcd_d    = {39'd0, bin_i[31]};
         sh_d     = bin_i << 1;
         cnt_d    = 5'd31;
         active_d = 1'b1;
      end else if (active_q) begin
         bcd_d = (adj << 1) | {39'd0, sh_q[31]};
         sh_d  = sh_q << 1;
         cnt_d = cnt_q - 5'd1;
         if (cnt_q == 5'd1) begin
            active_d = 1'b0;
            done_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         sh_q     <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         sh_q     <= sh_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   assign bcd_o  = bcd_q;
   assign done_o = done_q;

endmodule

// File: rtl/seg7_scan.sv
// 8-digit common-anode 7-segment display back-end.
// Snapshots {data_i, layout_i}, converts to hex or decimal digits, loads an
// 8-digit display buffer, and time-multiplexes the buffer onto the display.
//   clk_i     clock, rising edge
//   rst_i     synchronous reset, active-low
//   data_i    32-bit unsigned value
//   layout_i  [1:0] mode (00 hex, 01 dec, 10 blank, 11 hex),
//             [2] leading-zero blank, [3] dp on digit 0
//   an_o      digit enables, active-low
//   seg_o     {g,f,e,d,c,b,a}, active-low
//   dp_o      decimal point, active-low
//   busy_o    conversion in flight
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | compare inputs to snapshot; on difference capture and start
// S_SHIFT | decimal conversion running in bin2bcd (32 cycles)
// S_LOAD  | write all 8 digit codes into the display buffer
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] data_i,
   input  logic [3:0]  layout_i,
   output logic [7:0]  an_o,
   output logic [6:0]  seg_o,
   output logic        dp_o,
   output logic        busy_o
);

   localparam int            PW       = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);

   state_e      state_q, state_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  layout_q, layout_d;
   logic        snap_vld_q, snap_vld_d;
   logic        busy_q, busy_d;
   logic        changed;
   logic        bcd_start;
   logic        bcd_done;
   logic [39:0] bcd;
   logic        buf_we;

   logic [NDIGITS-1:0][6:0] buf_seg_q;
   logic [NDIGITS-1:0]      buf_dp_q;
   logic [NDIGITS-1:0][6:0] load_seg;
   logic [NDIGITS-1:0]      load_dp;
   logic [31:0]             digits;
   logic [3:0]              nib;
   logic                    nz_seen;
   logic                    ovf;
   logic                    unused_bcd_hi;

   logic [PW-1:0] presc_q;
   logic [2:0]    idx_q;
   logic [7:0]    an_q;
   logic [6:0]    seg_q;
   logic          dp_q;

   // Snapshot valid is cleared at reset so the first cycle always converts,
   // even when the inputs happen to match the cleared snapshot.
   assign changed = !snap_vld_q || (data_i != data_q) || (layout_i != layout_q);

   seg7_scan_bin2bcd u_bin2bcd (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (bcd_start),
      .bin_i   (data_i),
      .bcd_o   (bcd),
      .done_o  (bcd_done)
   );

   // Overflow is judged on the binary snapshot; the top two BCD digits are
   // never displayed.
   assign unused_bcd_hi = ^bcd[39:32];

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      layout_d   = layout_q;
      snap_vld_d = snap_vld_q;
      busy_d     = busy_q;
      bcd_start  = 1'b0;
      buf_we     = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (changed) begin
               data_d     = data_i;
               layout_d   = layout_i;
               snap_vld_d = 1'b1;
               busy_d     = 1'b1;
               if (layout_i[1:0] == MODE_DEC) begin
                  bcd_start = 1'b1;
                  state_d   = S_SHIFT;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_SHIFT: begin
            if (bcd_done) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // A result that is already stale is dropped; IDLE reconverts next
            // cycle so an intermediate value never reaches the display.
            buf_we  = !changed;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      digits   = (layout_q[1:0] == MODE_DEC) ? bcd[31:0] : data_q;
      ovf      = (layout_q[1:0] == MODE_DEC) && (data_q > DEC_MAX);
      nz_seen  = 1'b0;
      nib      = 4'd0;
      load_seg = {NDIGITS{GLYPH_BLANK}};
      load_dp  = '1;
      for (int k = NDIGITS - 1; k >= 0; k--) begin
         nib = digits[4*k +: 4];
         if (nib != 4'd0) begin
            nz_seen = 1'b1;
         end
         load_seg[k] = glyph(nib);
         load_dp[k]  = !(ovf || ((k == 0) && layout_q[3]));
         if (layout_q[2] && !nz_seen && (k != 0)) begin
            load_seg[k] = GLYPH_BLANK;
         end
         if (layout_q[1:0] == MODE_BLANK) begin
            load_seg[k] = GLYPH_BLANK;
            load_dp[k]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         data_q     <= '0;
         layout_q   <= '0;
         snap_vld_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         layout_q   <= layout_d;
         snap_vld_q <= snap_vld_d;
         busy_q     <= busy_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         buf_seg_q <= {NDIGITS{GLYPH_BLANK}};
         buf_dp_q  <= '1;
         presc_q   <= '0;
         idx_q     <= '0;
         an_q      <= 8'hFF;
         seg_q     <= GLYPH_BLANK;
         dp_q      <= 1'b1;
      end else begin
         if (buf_we) begin
            buf_seg_q <= load_seg;
            buf_dp_q  <= load_dp;
         end
         if (presc_q == PRESC_TC) begin
            presc_q <= '0;
            idx_q   <= idx_q + 3'd1;
         end else begin
            presc_q <= presc_q + PW'(1);
         end
         an_q  <= ~(8'd1 << idx_q);
         seg_q <= buf_seg_q[idx_q];
         dp_q  <= buf_dp_q[idx_q];
      end
   end

   assign an_o   = an_q;
   assign seg_o  = seg_q;
   assign dp_o   = dp_q;
   assign busy_o = busy_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Testbench for seg7_scan with REFRESH_DIV=4: table of display vectors plus
// hand-written sequences for reset, mid-conversion input change and
// mid-conversion reset.
module tb_seg7_scan;

   logic        clk_i    = 1'b0;
   logic        rst_i    = 1'b0;
   logic [31:0] data_i   = '0;
   logic [3:0]  layout_i = '0;
   logic [7:0]  an_o;
   logic [6:0]  seg_o;
   logic        dp_o;
   logic        busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   seg7_scan #(.REFRESH_DIV(4)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .data_i   (data_i),
      .layout_i (layout_i),
      .an_o     (an_o),
      .seg_o    (seg_o),
      .dp_o     (dp_o),
      .busy_o   (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0]     data;
      logic [3:0]      layout;
      logic [7:0][6:0] seg;   // index = digit, digit 0 rightmost
      logic [7:0]      dp;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive inputs at a falling edge and count the cycles busy_o stays high.
   task automatic apply_busy(input string name, input logic [31:0] d, input logic [3:0] l,
                             input int exp_busy);
      int cnt;
      data_i   = d;
      layout_i = l;
      cnt      = 0;
      @(negedge clk_i);
      while (busy_o === 1'b1 && cnt < 200) begin
         cnt++;
         @(negedge clk_i);
      end
      check({name, " busy cycles"}, cnt, exp_busy);
   endtask

   // Watch more than one full scan; collect every digit, check the anode walk.
   task automatic observe(input string name, input logic [7:0][6:0] exp_seg, input logic [7:0] exp_dp);
      logic [7:0][6:0] got_seg;
      logic [7:0]      got_dp;
      logic [7:0]      seen;
      logic [7:0]      prev_an;
      logic            bad_an;
      logic            walk_err;
      int              run;
      int              runs;
      int              idx;
      got_seg  = '1;
      got_dp   = '1;
      seen     = '0;
      prev_an  = 8'h00;
      bad_an   = 1'b0;
      walk_err = 1'b0;
      run      = 0;
      runs     = 0;
      repeat (2) @(negedge clk_i);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_i);
         idx = -1;
         for (int k = 0; k < 8; k++) begin
            if (an_o == ~(8'd1 << k)) idx = k;
         end
         if (idx < 0) begin
            bad_an = 1'b1;
         end else begin
            got_seg[idx] = seg_o;
            got_dp[idx]  = dp_o;
            seen[idx]    = 1'b1;
         end
         if (an_o != prev_an) begin
            if (runs >= 1 && an_o != {prev_an[6:0], prev_an[7]}) walk_err = 1'b1;
            if (runs >= 2 && run != 4) walk_err = 1'b1;
            runs++;
            run     = 1;
            prev_an = an_o;
         end else begin
            run++;
         end
      end
      check({name, " an one-hot"}, 32'(bad_an), 32'd0);
      check({name, " an walk"}, 32'(walk_err), 32'd0);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("%s digit%0d {seen,dp,seg}", name, k),
               {23'd0, seen[k], got_dp[k], got_seg[k]},
               {23'd0, 1'b1, exp_dp[k], exp_seg[k]});
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cnt;
      logic saw_first;

      //            data             layout   seg {d7..d0}                                                 dp
      vecs[0]  = '{32'd0,           4'b0000, {8{7'h40}},                                                   8'hFF};
      vecs[1]  = '{32'h12AB_CDEF,   4'b0000, {7'h79,7'h24,7'h08,7'h03,7'h46,7'h21,7'h06,7'h0E},            8'hFF};
      vecs[2]  = '{32'd1234,        4'b0101, {7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h24,7'h30,7'h19},            8'hFF};
      vecs[3]  = '{32'd4294967295,  4'b0001, {7'h10,7'h19,7'h10,7'h02,7'h78,7'h24,7'h10,7'h12},            8'h00};
      vecs[4]  = '{32'd100000000,   4'b0001, {8{7'h40}},                                                   8'h00};
      vecs[5]  = '{32'd99999999,    4'b0001, {8{7'h10}},                                                   8'hFF};
      vecs[6]  = '{32'd0,           4'b0101, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40},            8'hFF};
      vecs[7]  = '{32'h0000_0A00,   4'b1100, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h08,7'h40,7'h40},            8'hFE};
      vecs[8]  = '{32'hFFFF_FFFF,   4'b1010, {8{7'h7F}},                                                   8'hFF};
      vecs[9]  = '{32'h0000_00F0,   4'b0011, {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h0E,7'h40},            8'hFF};
      vecs[10] = '{32'd1000,        4'b1001, {7'h40,7'h40,7'h40,7'h40,7'h79,7'h40,7'h40,7'h40},            8'hFE};

      // reset held for 3 cycles
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         check($sformatf("reset cycle%0d {an,seg,dp,busy}", c),
               {15'd0, an_o, seg_o, dp_o, busy_o}, {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
      end

      // table: vector 0 is applied together with reset release
      for (int i = 0; i < 11; i++) begin
         if (i == 0) rst_i = 1'b1;
         apply_busy($sformatf("v%0d", i), vecs[i].data, vecs[i].layout,
                    (vecs[i].layout[1:0] == 2'b01) ? 34 : 2);
         observe($sformatf("v%0d", i), vecs[i].seg, vecs[i].dp);
      end

      // input changes 10 cycles into SHIFT: first result must never be shown
      data_i    = 32'd5000;
      layout_i  = 4'b0001;
      cnt       = 0;
      saw_first = 1'b0;
      for (int g = 0; g < 300; g++) begin
         @(negedge clk_i);
         if (seg_o == 7'h12) saw_first = 1'b1;
         if (busy_o !== 1'b1) break;
         cnt++;
         if (cnt == 10) data_i = 32'd7;
      end
      check("midshift busy cycles", cnt, 68);
      check("midshift first value shown", 32'(saw_first), 32'd0);
      observe("midshift", {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h78}, 8'hFF);

      // reset in the middle of a decimal conversion
      data_i   = 32'd55555;
      layout_i = 4'b0001;
      repeat (5) @(negedge clk_i);
      check("midreset busy before reset", 32'(busy_o), 32'd1);
      rst_i    = 1'b0;
      layout_i = 4'b1010;
      @(negedge clk_i);
      check("midreset {an,seg,dp,busy}",
            {15'd0, an_o, seg_o, dp_o, busy_o}, {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
      @(negedge clk_i);
      rst_i = 1'b1;
      apply_busy("midreset", 32'd55555, 4'b1010, 2);
      observe("midreset", {8{7'h7F}}, 8'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
